// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and the 7-segment decoder for the
// three-digit display path.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_LOAD = 2'd2
   } conv_state_e;

   localparam int         SEG7_NUM_DIGITS = 3;
   localparam logic [7:0] SEG7_BLANK      = 8'hFF;

   // Active-low segment pattern, bit 7 is DP (kept off). Non-decimal nibbles blank.
   function automatic logic [7:0] seg7_decode(input logic [3:0] nibble);
      logic [7:0] pat;
      case (nibble)
         4'd0:    pat = 8'hC0;
         4'd1:    pat = 8'hF9;
         4'd2:    pat = 8'hA4;
         4'd3:    pat = 8'hB0;
         4'd4:    pat = 8'h99;
         4'd5:    pat = 8'h92;
         4'd6:    pat = 8'h82;
         4'd7:    pat = 8'hF8;
         4'd8:    pat = 8'h80;
         4'd9:    pat = 8'h90;
         default: pat = SEG7_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: valid/ready capture of a binary value, serial double-dabble
// conversion (one bit per cycle) and the 12-bit BCD display register.
module bin2bcd_serial
   import seg7_pkg::*;
#(
   parameter int BIN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_data,
   output logic             busy,
   output logic [11:0]      bcd_out
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int SH_W  = 12 + BIN_W;

   conv_state_e      state_q, state_d;
   logic [BIN_W-1:0] sr_q, sr_d;
   logic [11:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      bcd_q, bcd_d;

   logic [11:0]      acc_adj;
   logic [SH_W-1:0]  shifted;
   logic             last_step;

   assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept in IDLE, BIN_W shift steps, one load cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_CONV;
         ST_CONV: if (last_step) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_CONV: busy     = 1'b1;
         ST_LOAD: busy     = 1'b1;
         default: ;
      endcase
   end

   // Add-3 to each nibble >= 5, then shift {acc, sr} left one bit
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 3; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      shifted = {acc_adj, sr_q} << 1;
   end

   // Datapath next-state; bcd only changes in LOAD so the display never tears
   always_comb begin
      sr_d  = sr_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      bcd_d = bcd_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sr_d  = in_data;
               acc_d = '0;
               cnt_d = '0;
            end
         end
         ST_CONV: begin
            sr_d  = shifted[BIN_W-1:0];
            acc_d = shifted[SH_W-1:BIN_W];
            cnt_d = cnt_q + 1'b1;
         end
         ST_LOAD: bcd_d = acc_q;
         default: ;
      endcase
   end

   // Datapath registers; reset aborts any conversion and clears the display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         bcd_q <= '0;
      end else begin
         sr_q  <= sr_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         bcd_q <= bcd_d;
      end
   end

   assign bcd_out = bcd_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary-to-BCD conversion plus time-multiplexed scan of three
// digits onto a shared active-low segment bus.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros).
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int BIN_W       = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIN_W-1:0]           in_data,
   output logic                       busy,
   output logic [11:0]                bcd_out,
   output logic [7:0]                 seg,
   output logic [SEG7_NUM_DIGITS-1:0] an
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [DIV_W-1:0]           div_q, div_d;
   logic [1:0]                 idx_q, idx_d;
   logic [7:0]                 seg_q, seg_d;
   logic [SEG7_NUM_DIGITS-1:0] an_q, an_d;
   logic                       wrap;
   logic [3:0]                 nib;
   logic                       blank;

   bin2bcd_serial #(.BIN_W(BIN_W)) u_conv (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .busy     (busy),
      .bcd_out  (bcd_out)
   );

   assign wrap = (div_q == DIV_W'(REFRESH_DIV - 1));

   // Refresh divider and digit index advance on wrap
   always_comb begin
      div_d = wrap ? '0 : div_q + 1'b1;
      idx_d = idx_q;
      if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
   end

   // Select the current digit's nibble and decide leading-zero blanking
   always_comb begin
      nib   = bcd_out[3:0];
      blank = 1'b0;
      case (idx_q)
         2'd1:    nib = bcd_out[7:4];
         2'd2:    nib = bcd_out[11:8];
         default: nib = bcd_out[3:0];
      endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      case (idx_q)
         2'd1:    blank = (bcd_out[11:4] == 8'h00);
         2'd2:    blank = (bcd_out[11:8] == 4'h0);
         default: blank = 1'b0;
      endcase
`endif
      seg_d = blank ? SEG7_BLANK : seg7_decode(nib);
      an_d  = ~(SEG7_NUM_DIGITS'(1) << idx_q);
   end

   // Scan state and registered pins; an and seg move together from the same index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
         seg_q <= SEG7_BLANK;
         an_q  <= '1;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven conversion/display vectors plus hand-written
// reset, scan, back-to-back and abort sequences.
module tb_seg7_scan_ctrl;

   localparam int BIN_W = 8;
   localparam int RDIV  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [BIN_W-1:0] in_data = '0;
   logic             in_ready;
   logic             busy;
   logic [11:0]      bcd_out;
   logic [7:0]       seg;
   logic [2:0]       an;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [7:0]  val;
      logic [11:0] bcd;
      logic [7:0]  su;
      logic [7:0]  st;
      logic [7:0]  sh;
   } vec_t;

   vec_t tbl[8];

   seg7_scan_ctrl #(.BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .busy     (busy),
      .bcd_out  (bcd_out),
      .seg      (seg),
      .an       (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_an(input logic [2:0] pat, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (an == pat) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Handshake one value and check latency and the loaded BCD value
   task automatic convert(input logic [7:0] val, input logic [11:0] exp_bcd, input string name);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = val;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hA5;
      check({name, " busy after accept"}, busy, 1);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, lat, BIN_W + 1);
      check({name, " bcd_out"}, bcd_out, exp_bcd);
   endtask

   // Check each digit's segment pattern as the scanner visits it
   task automatic check_digits(input vec_t v);
      bit ok;
      logic [7:0] eh, et;
      eh = v.sh;
      et = v.st;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (v.bcd[11:8] == 4'h0) eh = 8'hFF;
      if (v.bcd[11:4] == 8'h00) et = 8'hFF;
`endif
      repeat (2) @(negedge clk);
      wait_an(3'b110, ok);
      check("units an seen", ok, 1);
      check("units seg", seg, v.su);
      wait_an(3'b101, ok);
      check("tens an seen", ok, 1);
      check("tens seg", seg, et);
      wait_an(3'b011, ok);
      check("hundreds an seen", ok, 1);
      check("hundreds seg", seg, eh);
   endtask

   initial begin
      bit ok;

      tbl[0] = '{8'd0,   12'h000, 8'hC0, 8'hC0, 8'hC0};
      tbl[1] = '{8'd7,   12'h007, 8'hF8, 8'hC0, 8'hC0};
      tbl[2] = '{8'd10,  12'h010, 8'hC0, 8'hF9, 8'hC0};
      tbl[3] = '{8'd99,  12'h099, 8'h90, 8'h90, 8'hC0};
      tbl[4] = '{8'd100, 12'h100, 8'hC0, 8'hC0, 8'hF9};
      tbl[5] = '{8'd163, 12'h163, 8'hB0, 8'h82, 8'hF9};
      tbl[6] = '{8'd248, 12'h248, 8'h80, 8'h99, 8'hA4};
      tbl[7] = '{8'd255, 12'h255, 8'h92, 8'h92, 8'hA4};

      // Reset state
      #12;
      check("rst in_ready", in_ready, 1);
      check("rst busy", busy, 0);
      check("rst bcd_out", bcd_out, 12'h000);
      check("rst seg", seg, 8'hFF);
      check("rst an", an, 3'b111);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first edge an", an, 3'b110);
      check("first edge seg", seg, 8'hC0);

      // Scan rotation: each digit held RDIV cycles, exactly one enabled
      wait_an(3'b011, ok);
      check("scan find 011", ok, 1);
      wait_an(3'b110, ok);
      check("scan find 110", ok, 1);
      for (int i = 0; i < 13; i++) begin
         logic [2:0] exp_an;
         if (i > 0) @(negedge clk);
         case ((i / RDIV) % 3)
            0:       exp_an = 3'b110;
            1:       exp_an = 3'b101;
            default: exp_an = 3'b011;
         endcase
         check("scan an", an, exp_an);
         check("scan onehot", $countones(~an), 1);
      end

      // Table-driven conversions
      for (int i = 0; i < 8; i++) begin
         convert(tbl[i].val, tbl[i].bcd, "vec");
         check_digits(tbl[i]);
      end

      // Back-to-back: valid held high, 0 then 99
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd0;
      @(posedge clk);
      #1;
      in_data = 8'd99;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k < 9) check("b2b ready low in conv", in_ready, 0);
         if (k == 9) begin
            check("b2b first bcd", bcd_out, 12'h000);
            check("b2b ready after load", in_ready, 1);
         end
         if (k == 10) begin
            check("b2b second accept busy", busy, 1);
            check("b2b second accept ready", in_ready, 0);
         end
      end
      in_valid = 1'b0;
      for (int k = 0; k < 30 && busy; k++) @(posedge clk);
      #1;
      check("b2b second bcd", bcd_out, 12'h099);

      // Abort: reset on 4th conversion cycle of 200
      convert(8'd255, 12'h255, "pre-abort");
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort bcd_out", bcd_out, 12'h000);
      check("abort busy", busy, 0);
      check("abort in_ready", in_ready, 1);
      check("abort seg", seg, 8'hFF);
      check("abort an", an, 3'b111);
      @(negedge clk);
      rst = 1'b0;
      repeat (BIN_W + 2) @(posedge clk);
      #1;
      check("abort no partial load", bcd_out, 12'h000);
      convert(8'd200, 12'h200, "post-abort");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Sequencing controller for the three-digit 7-segment display path. Accepts a binary value over a valid/ready handshake and converts it to three packed BCD digits with a serial shift-add-3 (double-dabble) engine, one bit per cycle. Holds the result in a display register and time-multiplexes the three digits onto one shared active-low segment bus with active-low digit enables. Sits between the core's output/debug register and the board's display pins.

## Interface
- `BIN_W`, default 8: input value width; legal range 1..9, so the maximum value 511 always fits in three digits.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal values are 2 and above.
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` is presented.
- `in_ready`  out  1: controller can accept a value; high only in IDLE.
- `in_data`  in  BIN_W: unsigned binary value to display.
- `busy`  out  1: conversion in progress (CONV or LOAD).
- `bcd_out`  out  12: display register, packed as {hundreds, tens, units}.
- `seg`  out  8: active-low segments; bit 7 is DP, always 1.
- `an`  out  3: active-low digit enables; bit 0 units, bit 1 tens, bit 2 hundreds.

## Operation
- FSM states: IDLE, CONV, LOAD.
  - IDLE: `in_ready`=1. On `in_valid` && `in_ready`, capture `in_data` into the shift register, clear the BCD accumulator and bit counter, then go to CONV.
  - CONV: one step per cycle. First add 3 to every accumulator nibble that is ≥5, then shift {accumulator, shift register} left by 1. After BIN_W steps, go to LOAD.
  - LOAD: copy the accumulator to `bcd_out`, then return to IDLE.
- `in_valid` is ignored outside IDLE. The value does not need to stay stable after acceptance.
- The display keeps showing the previous `bcd_out` for the whole conversion, so digits never tear.
- Scanner behaviour:
  - A free-running counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - `an` is the one-hot-low encoding of the index. `seg` is the decode of the selected nibble.
- Decode uses standard active-low patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any other nibble decodes to FF (blank).
- The accumulator is 12 bits and the add-3 step is applied per nibble. No carry out of the hundreds digit is possible for BIN_W≤9.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `bcd_out`=000, `seg`=FF, `an`=111. FSM is in IDLE; scan counter and index are 0.
- `seg` and `an` are registered. At the first edge after reset release: `an`=110, `seg`=C0.
- Latency: handshake at edge N → `busy`=1 from N through N+BIN_W+1 → `bcd_out` updated at edge N+BIN_W+1 → `in_ready`=1 after that edge.
- Minimum accept-to-accept spacing is BIN_W+2 cycles.
- `seg` reflects a new `bcd_out` one cycle after the update, on whichever digit is currently enabled.
- Simultaneous LOAD and scan wrap: the new index decodes the new `bcd_out`.
- Reset mid-conversion aborts immediately, clears `bcd_out` to 000 and returns to IDLE. No partial value is ever loaded.

## Configuration
- Macro: `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined:
  - The hundreds digit shows FF when its nibble is 0.
  - The tens digit shows FF when the hundreds and tens nibbles are both 0.
  - The units digit is never blanked.
  - `an` is unaffected.
- Undefined: all three digits always display, so 7 shows as "007".

## Structure
- Package `seg7_pkg` holds:
  - FSM state enum;
  - `SEG7_NUM_DIGITS`=3;
  - `SEG7_BLANK`=8'hFF;
  - a `seg7_decode(nibble)` function returning the 8-bit pattern.
- Sub-module `bin2bcd_serial`: the handshake, FSM, shift/add-3 engine and `bcd_out` register.
- The top level contains the scan counter, digit mux, blanking logic and output registers.

## Test plan
- Reset: assert `rst` mid-run → outputs go to reset values immediately. Release → `an`=110 and `seg`=C0 after one edge.
- Convert 255, BIN_W=8: `bcd_out`=255 exactly 9 cycles after the handshake edge. With REFRESH_DIV=4: units `seg`=92, tens 92, hundreds A4.
- Scan rotation, REFRESH_DIV=4: `an` cycles 110→101→011→110, each held 4 cycles, with no cycle where two digits are enabled.
- Back-to-back: `in_valid` held high with 0 then 99 → second accept one cycle after the first LOAD. `bcd_out` goes 000 then 099. `in_ready`=0 throughout CONV.
- Abort: `rst` pulsed on the 4th CONV cycle of 200 → `bcd_out`=000. A subsequent 200 converts correctly.
- Blanking macro, value 7: with the macro, hundreds and tens `seg`=FF and units `seg`=F8. Without it, hundreds and tens show C0.
